// File: rtl/regfile_multiport_sb.sv
// Integer register file with NUM_RD combinational read ports, two write lanes and a per-register busy scoreboard.
// Optional write-through forwarding on reads is enabled by defining RF_BYPASS_EN.
module regfile_multiport_sb #(
  parameter int RF_ADDR_LEN = 5,
  parameter int RF_DATA_LEN = 32,
  parameter int NUM_RD      = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_RD*RF_ADDR_LEN-1:0] rd_addr,
  output logic [NUM_RD*RF_DATA_LEN-1:0] rd_data,
  output logic [NUM_RD-1:0]             rd_busy,
  output logic                          hazard,
  input  logic                          iss_en,
  input  logic [RF_ADDR_LEN-1:0]        iss_rd,
  input  logic                          wb0_en,
  input  logic [RF_ADDR_LEN-1:0]        wb0_addr,
  input  logic [RF_DATA_LEN-1:0]        wb0_data,
  input  logic                          wb1_en,
  input  logic [RF_ADDR_LEN-1:0]        wb1_addr,
  input  logic [RF_DATA_LEN-1:0]        wb1_data
);

  localparam int DEPTH = 2 ** RF_ADDR_LEN;

  logic [RF_DATA_LEN-1:0] regs_q [DEPTH];
  logic [RF_DATA_LEN-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]       busy_q;
  logic [DEPTH-1:0]       busy_d;

  logic wb0_act_s;
  logic wb1_act_s;
  logic iss_act_s;

  assign wb0_act_s = wb0_en && (wb0_addr != {RF_ADDR_LEN{1'b0}});
  assign wb1_act_s = wb1_en && (wb1_addr != {RF_ADDR_LEN{1'b0}});
  assign iss_act_s = iss_en && (iss_rd != {RF_ADDR_LEN{1'b0}});

  // Next array and scoreboard state; lane 1 is applied last so it wins a same-address collision.
  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      regs_d[r] = regs_q[r];
    end
    busy_d = busy_q;
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs_d[r] = {RF_DATA_LEN{1'b0}};
      end
      busy_d = {DEPTH{1'b0}};
    end else begin
      if (wb0_act_s) begin
        regs_d[wb0_addr] = wb0_data;
      end else begin
        regs_d[0] = {RF_DATA_LEN{1'b0}};
      end
      if (wb1_act_s) begin
        regs_d[wb1_addr] = wb1_data;
      end else begin
        regs_d[0] = {RF_DATA_LEN{1'b0}};
      end
      // Issue beats writeback clear on the same register in the same cycle.
      for (int r = 1; r < DEPTH; r++) begin
        if (iss_act_s && (iss_rd == RF_ADDR_LEN'(r))) begin
          busy_d[r] = 1'b1;
        end else if ((wb0_en && (wb0_addr == RF_ADDR_LEN'(r))) ||
                     (wb1_en && (wb1_addr == RF_ADDR_LEN'(r)))) begin
          busy_d[r] = 1'b0;
        end else begin
          busy_d[r] = busy_q[r];
        end
      end
    end
    regs_d[0] = {RF_DATA_LEN{1'b0}};
    busy_d[0] = 1'b0;
  end

  // Array and scoreboard state registers.
  always_ff @(posedge clk) begin
    for (int r = 0; r < DEPTH; r++) begin
      regs_q[r] <= regs_d[r];
    end
    busy_q <= busy_d;
  end

  // Combinational read ports, x0 forced to zero and never busy.
  always_comb begin
    rd_data = {(NUM_RD*RF_DATA_LEN){1'b0}};
    rd_busy = {NUM_RD{1'b0}};
    for (int k = 0; k < NUM_RD; k++) begin
      logic [RF_ADDR_LEN-1:0] a;
      a = rd_addr[k*RF_ADDR_LEN +: RF_ADDR_LEN];
      if (a == {RF_ADDR_LEN{1'b0}}) begin
        rd_data[k*RF_DATA_LEN +: RF_DATA_LEN] = {RF_DATA_LEN{1'b0}};
        rd_busy[k] = 1'b0;
`ifdef RF_BYPASS_EN
      end else if (wb1_act_s && (wb1_addr == a)) begin
        rd_data[k*RF_DATA_LEN +: RF_DATA_LEN] = wb1_data;
        rd_busy[k] = iss_en && (iss_rd == a);
      end else if (wb0_act_s && (wb0_addr == a)) begin
        rd_data[k*RF_DATA_LEN +: RF_DATA_LEN] = wb0_data;
        rd_busy[k] = iss_en && (iss_rd == a);
`endif
      end else begin
        rd_data[k*RF_DATA_LEN +: RF_DATA_LEN] = regs_q[a];
        rd_busy[k] = busy_q[a];
      end
    end
  end

  assign hazard = |rd_busy;

endmodule
